// File: rtl/redmule_mesh_pkg.sv
// Shared types and constants for the RedMulE mesh tile sequencer.
package redmule_mesh_pkg;

  localparam int unsigned MESH_SEQ_CYCLES_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ENABLE,
    RELEASE,
    RUN,
    DONE
  } mesh_seq_state_e;

endpackage

// File: rtl/redmule_mesh_sleep_filter.sv
// Per-tile sleep filter: a sticky done bit is set after SLEEP_FILTER consecutive
// enabled cycles with core_sleep high.
module redmule_mesh_sleep_filter #(
  parameter int unsigned SLEEP_FILTER = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  input  logic sleep_i,
  output logic done_o
);

  localparam int unsigned CNT_W = (SLEEP_FILTER > 1) ? $clog2(SLEEP_FILTER) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (enable_i && sleep_i) begin
      // Counter holds at its top value; the done bit records the threshold.
      if (cnt_q == CNT_W'(SLEEP_FILTER - 1)) begin
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/redmule_mesh_tile_sequencer.sv
// Per-mesh boot/completion sequencer: staggered fetch-enable release and
// filtered core_sleep completion detection. Timeout logic: REDMULE_MESH_SEQ_TIMEOUT_EN.
module redmule_mesh_tile_sequencer
  import redmule_mesh_pkg::*;
#(
  parameter int unsigned N_TILES        = 4,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned SLEEP_FILTER   = 4,
  parameter int unsigned HARTID_BASE    = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [N_TILES-1:0]           tile_mask_i,
  input  logic [31:0]                  timeout_limit_i,
  input  logic [N_TILES-1:0]           core_sleep_i,
  output logic [N_TILES-1:0]           tile_enable_o,
  output logic [N_TILES-1:0]           fetch_enable_o,
  output logic [N_TILES*32-1:0]        mhartid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic [N_TILES-1:0]           done_mask_o,
  output logic [MESH_SEQ_CYCLES_W-1:0] cycles_o
);

  localparam int unsigned STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  mesh_seq_state_e              state_q, state_d;
  logic [N_TILES-1:0]           mask_q, mask_d;
  logic [N_TILES-1:0]           ten_q, ten_d;
  logic [N_TILES-1:0]           fen_q, fen_d;
  logic [N_TILES-1:0]           rem_q, rem_d;
  logic [STG_W-1:0]             stag_q, stag_d;
  logic [MESH_SEQ_CYCLES_W-1:0] cyc_q, cyc_d;
  logic                         to_flag_q, to_flag_d;

  logic               start_acc;
  logic               timeout_hit;
  logic               release_now;
  logic               filter_phase;
  logic [N_TILES-1:0] first_sel;
  logic [N_TILES-1:0] next_sel;
  logic [N_TILES-1:0] filt_en;

  // Lowest set bit of a vector: x & -x.
  assign first_sel   = mask_q & (~mask_q + N_TILES'(1));
  assign next_sel    = rem_q & (~rem_q + N_TILES'(1));
  assign release_now = (STAGGER_CYCLES <= 1) || (stag_q == STG_W'(STAGGER_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      ten_q     <= '0;
      fen_q     <= '0;
      rem_q     <= '0;
      stag_q    <= '0;
      cyc_q     <= '0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ten_q     <= ten_d;
      fen_q     <= fen_d;
      rem_q     <= rem_d;
      stag_q    <= stag_d;
      cyc_q     <= cyc_d;
      to_flag_q <= to_flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ten_d     = ten_q;
    fen_d     = fen_q;
    rem_d     = rem_q;
    stag_d    = stag_q;
    cyc_d     = cyc_q;
    to_flag_d = to_flag_q;
    start_acc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          mask_d    = tile_mask_i;
          cyc_d     = '0;
          to_flag_d = 1'b0;
          if (tile_mask_i == '0) begin
            state_d = DONE;
          end else begin
            ten_d   = tile_mask_i;
            state_d = ENABLE;
          end
        end
      end
      ENABLE: begin
        state_d = RELEASE;
        stag_d  = '0;
        if (STAGGER_CYCLES == 0) begin
          fen_d = mask_q;
          rem_d = '0;
        end else begin
          fen_d = first_sel;
          rem_d = mask_q & ~first_sel;
        end
      end
      RELEASE: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + MESH_SEQ_CYCLES_W'(1);
        if (rem_q == '0) begin
          state_d = RUN;
        end else if (release_now) begin
          fen_d  = fen_q | next_sel;
          rem_d  = rem_q & ~next_sel;
          stag_d = '0;
        end else begin
          stag_d = stag_q + STG_W'(1);
        end
      end
      RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + MESH_SEQ_CYCLES_W'(1);
        // Completion takes priority over a coincident timeout.
        if (done_mask_o == mask_q) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d   = DONE;
          to_flag_d = 1'b1;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
          ten_d   = '0;
          fen_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REDMULE_MESH_SEQ_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (start_acc) begin
      to_cnt_q <= '0;
    end else if (state_q == RUN) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = (timeout_limit_i != '0) && (to_cnt_q == timeout_limit_i);
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^timeout_limit_i;
  assign timeout_hit          = 1'b0;
`endif

  assign filter_phase = (state_q == RELEASE) || (state_q == RUN);
  assign filt_en      = fen_q & {N_TILES{filter_phase}};

  for (genvar i = 0; i < N_TILES; i++) begin : g_filter
    redmule_mesh_sleep_filter #(
      .SLEEP_FILTER(SLEEP_FILTER)
    ) u_filter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (start_acc),
      .enable_i(filt_en[i]),
      .sleep_i (core_sleep_i[i]),
      .done_o  (done_mask_o[i])
    );
    assign mhartid_o[i*32 +: 32] = 32'(HARTID_BASE + i);
  end

  assign tile_enable_o  = ten_q;
  assign fetch_enable_o = fen_q;
  assign busy_o         = (state_q == ENABLE) || (state_q == RELEASE) || (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign timeout_o      = (state_q == DONE) && to_flag_q;
  assign cycles_o       = cyc_q;

endmodule

// File: tb/tb_redmule_mesh_tile_sequencer.sv
// Self-checking bench for redmule_mesh_tile_sequencer against a cycle-arithmetic model.
module tb_redmule_mesh_tile_sequencer;

  localparam int NT  = 4;
  localparam int SG  = 8;
  localparam int SF  = 4;
  localparam int HB  = 16;
  localparam int INF = 1000000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NT-1:0]   mask_in = '0;
  logic [31:0]     limit = '0;
  logic [NT-1:0]   sleep = '0;
  logic [NT-1:0]   tile_enable_o, fetch_enable_o, done_mask_o;
  logic [NT*32-1:0] mhartid_o;
  logic            busy_o, done_o, timeout_o;
  logic [63:0]     cycles_o;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int sl_off[NT];
  int gl_off[NT];

  always #5 clk = ~clk;

  redmule_mesh_tile_sequencer #(
    .N_TILES(NT),
    .STAGGER_CYCLES(SG),
    .SLEEP_FILTER(SF),
    .HARTID_BASE(HB)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .tile_mask_i(mask_in),
    .timeout_limit_i(limit),
    .core_sleep_i(sleep),
    .tile_enable_o(tile_enable_o),
    .fetch_enable_o(fetch_enable_o),
    .mhartid_o(mhartid_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o),
    .done_mask_o(done_mask_o),
    .cycles_o(cycles_o)
  );

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Tile i sleeps permanently from offset sl_off[i] and pulses for 3 cycles at gl_off[i].
  task automatic drive_sleep(input int t0);
    int c;
    c = cyc - t0;
    for (int i = 0; i < NT; i++)
      sleep[i] = (sl_off[i] >= 0 && c >= sl_off[i]) ||
                 (gl_off[i] >= 0 && c >= gl_off[i] && c < gl_off[i] + 3);
  endtask

  task automatic run_case(input string name, input logic [NT-1:0] m_in, input int lim, input bit hold);
    int t0, m, run_e, cc, d_comp, d_to, dexp, dlen, cyc_exp, end_c, sa;
    int rel[NT];
    int dn[NT];
    bit to_exp, in_run;
    logic [NT-1:0] ten_e, fen_e, dm_e;
    logic busy_e, done_e, tmo_e;
    t0 = cyc; m = 0; cc = 0; to_exp = 0; run_e = t0 + 3;
    for (int i = 0; i < NT; i++) begin
      if (m_in[i]) begin rel[i] = t0 + 2 + m * SG; m++; end
      else rel[i] = INF;
    end
    if (m > 0) run_e = t0 + 3 + (m - 1) * SG;
    for (int i = 0; i < NT; i++) begin
      dn[i] = INF;
      if (m_in[i] && sl_off[i] >= 0) begin
        sa = t0 + sl_off[i];
        dn[i] = imax(sa, rel[i]) + SF;
      end
      if (m_in[i]) cc = imax(cc, dn[i]);
    end
    if (m == 0) begin
      dexp = t0 + 1; cyc_exp = 0;
    end else begin
      d_comp = (cc >= INF) ? INF : imax(cc, run_e) + 1;
      d_to = INF;
`ifdef REDMULE_MESH_SEQ_TIMEOUT_EN
      if (lim != 0) d_to = run_e + lim + 1;
`endif
      if (d_comp <= d_to) dexp = d_comp;
      else begin dexp = d_to; to_exp = 1; end
      cyc_exp = dexp - t0 - 2;
    end
    dlen  = hold ? 3 : 1;
    end_c = (dexp >= INF) ? run_e + lim + 40 : dexp + dlen;

    start = 1'b1; mask_in = m_in; limit = 32'(lim);
    drive_sleep(t0);
    while (cyc < end_c) begin
      step();
      start   = hold ? (cyc < dexp + dlen - 1) : 1'b0;
      mask_in = NT'($urandom);
      drive_sleep(t0);
      in_run = (cyc >= t0 + 1) && (cyc < dexp + dlen);
      ten_e  = in_run ? m_in : '0;
      for (int i = 0; i < NT; i++) begin
        fen_e[i] = in_run && (cyc >= rel[i]);
        dm_e[i]  = (dn[i] <= cyc) && (dn[i] <= dexp);
      end
      busy_e = (cyc >= t0 + 1) && (cyc < dexp);
      done_e = (cyc >= dexp) && (cyc < dexp + dlen);
      tmo_e  = done_e && to_exp;
      total++;
      if (tile_enable_o !== ten_e) begin
        bad++; $display("FAIL %s tile_enable t+%0d got=%b exp=%b", name, cyc - t0, tile_enable_o, ten_e);
      end
      total++;
      if (fetch_enable_o !== fen_e) begin
        bad++; $display("FAIL %s fetch_enable t+%0d got=%b exp=%b", name, cyc - t0, fetch_enable_o, fen_e);
      end
      total++;
      if (busy_o !== busy_e) begin
        bad++; $display("FAIL %s busy t+%0d got=%b exp=%b", name, cyc - t0, busy_o, busy_e);
      end
      total++;
      if (done_o !== done_e) begin
        bad++; $display("FAIL %s done t+%0d got=%b exp=%b", name, cyc - t0, done_o, done_e);
      end
      total++;
      if (done_mask_o !== dm_e) begin
        bad++; $display("FAIL %s done_mask t+%0d got=%b exp=%b", name, cyc - t0, done_mask_o, dm_e);
      end
      total++;
      if (timeout_o !== tmo_e) begin
        bad++; $display("FAIL %s timeout t+%0d got=%b exp=%b", name, cyc - t0, timeout_o, tmo_e);
      end
      if (cyc >= dexp) begin
        total++;
        if (cycles_o !== 64'(cyc_exp)) begin
          bad++; $display("FAIL %s cycles t+%0d got=%0d exp=%0d", name, cyc - t0, cycles_o, cyc_exp);
        end
      end
    end
    start = 1'b0;
    if (dexp >= INF) begin
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
    end
  endtask

  task automatic set_sleep(input int s0, input int s1, input int s2, input int s3);
    sl_off[0] = s0; sl_off[1] = s1; sl_off[2] = s2; sl_off[3] = s3;
    for (int i = 0; i < NT; i++) gl_off[i] = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({tile_enable_o, fetch_enable_o, busy_o, done_o, timeout_o, done_mask_o} !== '0 || cycles_o !== 64'd0) begin
      bad++; $display("FAIL reset outputs got_en=%b got_fe=%b busy=%b done=%b", tile_enable_o, fetch_enable_o, busy_o, done_o);
    end
    for (int i = 0; i < NT; i++) begin
      total++;
      if (mhartid_o[i*32 +: 32] !== 32'(HB + i)) begin
        bad++; $display("FAIL mhartid[%0d] got=%0d exp=%0d", i, mhartid_o[i*32 +: 32], HB + i);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stagger_full();
    set_sleep(40, 45, 50, 55);
    run_case("stagger_full", 4'b1111, 0, 1'b0);
  endtask

  task automatic test_mask_1010();
    set_sleep(0, 20, 0, 5);
    run_case("mask_1010", 4'b1010, 0, 1'b0);
  endtask

  task automatic test_glitch();
    set_sleep(30, 12, 0, 0);
    gl_off[0] = 5;
    run_case("glitch", 4'b0011, 0, 1'b0);
  endtask

  task automatic test_timeout();
    set_sleep(3, 3, -1, 3);
    run_case("timeout", 4'b1111, 100, 1'b0);
  endtask

  task automatic test_tie();
    set_sleep(9, 0, 0, 0);
    run_case("tie", 4'b0001, 10, 1'b0);
  endtask

  task automatic test_mask_zero();
    set_sleep(0, 0, 0, 0);
    run_case("mask_zero", 4'b0000, 0, 1'b0);
  endtask

  task automatic test_hold_start();
    set_sleep(2, 7, 9, 1);
    run_case("hold_start", 4'b0110, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    set_sleep(6, 0, 0, 4);
    run_case("b2b_a", 4'b1001, 0, 1'b0);
    set_sleep(0, 3, 3, 0);
    run_case("b2b_b", 4'b0110, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [NT-1:0] m;
    int lim;
    for (int n = 0; n < 6; n++) begin
      m = NT'($urandom_range(1, 15));
      for (int i = 0; i < NT; i++) begin
        sl_off[i] = $urandom_range(0, 50);
        if ($urandom_range(0, 1) == 1 && sl_off[i] >= 4) gl_off[i] = $urandom_range(0, sl_off[i] - 4);
        else gl_off[i] = -1;
      end
      lim = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(15, 60));
      run_case("random", m, lim, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    set_sleep(0, 0, 0, 0);
    t0 = cyc;
    start = 1'b1; mask_in = 4'b1111; limit = '0;
    drive_sleep(t0);
    while (cyc < t0 + 5) begin
      step();
      start = 1'b0;
    end
    total++;
    if (fetch_enable_o !== 4'b0001 || busy_o !== 1'b1) begin
      bad++; $display("FAIL reset_mid pre fe=%b busy=%b exp fe=0001 busy=1", fetch_enable_o, busy_o);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tile_enable_o, fetch_enable_o, busy_o, done_o, timeout_o, done_mask_o} !== '0 || cycles_o !== 64'd0) begin
      bad++; $display("FAIL reset_mid async en=%b fe=%b busy=%b dm=%b cyc=%0d exp all 0", tile_enable_o, fetch_enable_o, busy_o, done_mask_o, cycles_o);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || tile_enable_o !== '0 || fetch_enable_o !== '0) begin
        bad++; $display("FAIL reset_mid idle busy=%b done=%b en=%b fe=%b exp 0", busy_o, done_o, tile_enable_o, fetch_enable_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stagger_full();
    test_mask_1010();
    test_glitch();
    test_timeout();
    test_tie();
    test_mask_zero();
    test_hold_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
